// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: one byte pushed per cycle, 1..PEEK bytes retired per pull, single-cycle flush.
// Outputs depend only on registered state; overrun/underrun pulse for the cycle after a rejected request.
module inst_prefetch_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PEEK   = 3
) (
  input  logic                       clk,
  input  logic                       queue_reset_n,
  input  logic                       queue_flush,
  input  logic [DATA_W-1:0]          queue_in,
  input  logic                       queue_push,
  input  logic                       queue_pull,
  input  logic [$clog2(PEEK+1)-1:0]  queue_pull_len,
  output logic [PEEK*DATA_W-1:0]     queue_out,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       queue_empty,
  output logic                       queue_full,
  output logic                       queue_overrun,
  output logic                       queue_underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(PEEK + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LW-1:0] PEEK_C  = LW'(PEEK);

  logic [DATA_W-1:0] storage [DEPTH];
  logic [PW-1:0]     ptr_s;
  logic [PW-1:0]     ptr_e;
  logic [CW-1:0]     count;
  logic              overrun;
  logic              underrun;

  logic              push_acc;
  logic              pull_req;
  logic              pull_ok;
  logic              pull_rej;
  logic [CW-1:0]     pull_amt;
  logic [CW-1:0]     count_next;
  logic [PW-1:0]     ptr_s_next;

  always_comb begin
    push_acc   = queue_push && (count != DEPTH_C);
    pull_req   = queue_pull && (queue_pull_len != '0);
    pull_ok    = pull_req && (queue_pull_len <= PEEK_C) && (CW'(queue_pull_len) <= count);
    pull_rej   = pull_req && !pull_ok;
    pull_amt   = pull_ok ? CW'(queue_pull_len) : '0;
    // A push is only accepted below DEPTH, so count+push never exceeds DEPTH and CW bits suffice.
    count_next = count + CW'(push_acc) - pull_amt;
    ptr_s_next = ptr_s + PW'(pull_amt);
  end

  always_ff @(posedge clk) begin
    if (!queue_reset_n) begin
      ptr_s    <= '0;
      ptr_e    <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (queue_flush) begin
      ptr_s    <= '0;
      ptr_e    <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push_acc)
        ptr_e <= ptr_e + PW'(1);
      ptr_s    <= ptr_s_next;
      count    <= count_next;
      overrun  <= queue_push && !push_acc;
      underrun <= pull_rej;
    end
  end

  always_ff @(posedge clk) begin
    if (queue_reset_n && !queue_flush && push_acc)
      storage[ptr_e] <= queue_in;
  end

  // Bytes beyond the current occupancy read as zero so stale storage never reaches the decoder.
  always_comb begin
    queue_out = '0;
    for (int i = 0; i < PEEK; i++) begin
      if (CW'(i) < count)
        queue_out[i*DATA_W +: DATA_W] = storage[ptr_s + PW'(i)];
    end
  end

  assign queue_count    = count;
  assign queue_empty    = (count == '0);
  assign queue_full     = (count == DEPTH_C);
  assign queue_overrun  = overrun;
  assign queue_underrun = underrun;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed checks for inst_prefetch_queue (DEPTH=16, PEEK=3): table vectors plus fill, wrap and flush/reset sequences.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        queue_reset_n = 1'b0;
  logic        queue_flush = 1'b0;
  logic [7:0]  queue_in = '0;
  logic        queue_push = 1'b0;
  logic        queue_pull = 1'b0;
  logic [1:0]  queue_pull_len = '0;
  logic [23:0] queue_out;
  logic [4:0]  queue_count;
  logic        queue_empty;
  logic        queue_full;
  logic        queue_overrun;
  logic        queue_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  inst_prefetch_queue #(.DATA_W(8), .DEPTH(16), .PEEK(3)) dut (
    .clk            (clk),
    .queue_reset_n  (queue_reset_n),
    .queue_flush    (queue_flush),
    .queue_in       (queue_in),
    .queue_push     (queue_push),
    .queue_pull     (queue_pull),
    .queue_pull_len (queue_pull_len),
    .queue_out      (queue_out),
    .queue_count    (queue_count),
    .queue_empty    (queue_empty),
    .queue_full     (queue_full),
    .queue_overrun  (queue_overrun),
    .queue_underrun (queue_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        push;
    logic [7:0]  din;
    logic        pull;
    logic [1:0]  len;
    int          cnt;
    logic [23:0] out;
    logic        ovr;
    logic        udr;
  } vec_t;

  vec_t tbl [10];

  task automatic step(input logic rst_n, input logic flush, input logic push,
                      input logic [7:0] din, input logic pull, input logic [1:0] len);
    @(negedge clk);
    queue_reset_n  = rst_n;
    queue_flush    = flush;
    queue_push     = push;
    queue_in       = din;
    queue_pull     = pull;
    queue_pull_len = len;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic check(input string tag, input int cnt, input logic [23:0] out,
                       input logic ovr, input logic udr);
    n_tests++;
    if (queue_out !== out) begin
      n_fail++;
      $display("FAIL %s out: got %h want %h", tag, queue_out, out);
    end
    cmp({tag, " count"}, int'(queue_count), cnt);
    cmp({tag, " empty"}, int'(queue_empty), int'(cnt == 0));
    cmp({tag, " full"}, int'(queue_full), int'(cnt == 16));
    cmp({tag, " overrun"}, int'(queue_overrun), int'(ovr));
    cmp({tag, " underrun"}, int'(queue_underrun), int'(udr));
  endtask

  initial begin
    logic [7:0] b0, b1, b2;

    //         rst   flush push  din    pull  len   cnt out        ovr   udr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 24'h000000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'hA9, 1'b0, 2'd0, 1, 24'h0000A9, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 2'd0, 2, 24'h0042A9, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h8D, 1'b0, 2'd0, 3, 24'h8D42A9, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 2'd2, 2, 24'h00008D, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 2, 24'h00008D, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 2, 24'h00008D, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 2, 24'h00008D, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 0, 24'h000000, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 0, 24'h000000, 1'b0, 1'b1};

    for (int v = 0; v < 10; v++) begin
      step(tbl[v].rst_n, tbl[v].flush, tbl[v].push, tbl[v].din, tbl[v].pull, tbl[v].len);
      check($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].out, tbl[v].ovr, tbl[v].udr);
    end

    // Fill to DEPTH, then overrun and a pull+push while full (push must be dropped).
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b1, 8'h10 + 8'(k), 1'b0, 2'd0);
    check("fill", 16, 24'h121110, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 2'd0);
    check("overrun", 16, 24'h121110, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
    check("overrun_clear", 16, 24'h121110, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 2'd3);
    check("full_pull_push", 13, 24'h151413, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3);
    check("drain1", 10, 24'h181716, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3);
    check("drain2", 7, 24'h1B1A19, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3);
    check("drain3", 4, 24'h1E1D1C, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3);
    check("drain4", 1, 24'h00001F, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1);
    check("drain5", 0, 24'h000000, 1'b0, 1'b0);

    // Steady stream across the pointer wrap: count stays 3, window slides by one.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    check("flush0", 0, 24'h000000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 8'h40 + 8'(k), 1'b0, 2'd0);
    check("prime", 3, 24'h424140, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, 8'h43 + 8'(k), 1'b1, 2'd1);
      b0 = 8'h41 + 8'(k);
      b1 = 8'h42 + 8'(k);
      b2 = 8'h43 + 8'(k);
      check($sformatf("wrap%0d", k), 3, {b2, b1, b0}, 1'b0, 1'b0);
    end

    // Flush beats same-cycle push and pull.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 8'h60 + 8'(k), 1'b0, 2'd0);
    check("five", 5, 24'h626160, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 2'd3);
    check("flush_all", 0, 24'h000000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
    check("flush_idle", 0, 24'h000000, 1'b0, 1'b0);

    // Reset beats everything, including an underrun that would otherwise pulse.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 8'h70 + 8'(k), 1'b0, 2'd0);
    check("five_b", 5, 24'h727170, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd3);
    check("pull3_of5", 2, 24'h007473, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 2'd3);
    check("reset_all", 0, 24'h000000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 2'd0);
    check("after_reset", 1, 24'h00005A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
